phase_driver: RTL and testbench

Downstream stage of the host receiver. Consumes the per-channel phase words the receiver decodes and drives NUM_CHANNELS phase-shifted 50%-duty square waves at OUT_FREQ, one per transducer.
- Phase updates are double-buffered and applied only at period boundaries, so outputs never glitch.
- Start and stop are aligned to period boundaries.

---
 rtl/phase_driver.sv | 165 ++++++++++++++++
 tb/tb_phase_driver.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_driver.sv
// rtl/phase_driver.sv - phase-shifted square-wave driver with period-aligned updates
//
// Purpose: drives NUM_CHANNELS 50%-duty square waves at OUT_FREQ. Each channel is
// delayed by its own phase, given in clock ticks. New phases are held in a shadow
// bank and only reach the active bank at a period boundary, so an output never
// glitches. Start and stop are also aligned to period boundaries.
//
// Optional macro: PHASE_DRIVER_SYNC_OUT_EN adds the sync_out port.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-low reset
//   en           in   run request (level)
//   phases       in   NUM_CHANNELS x PHASE_W phase words, in clock ticks
//   phases_valid in   one-cycle strobe that captures phases
//   pending      out  shadow bank holds phases that are not yet applied
//   running      out  outputs are currently toggling
//   outs         out  square-wave outputs, one per channel
//   sync_out     out  (PHASE_DRIVER_SYNC_OUT_EN only) pulse at cnt==0 while running

module phase_driver #(
  parameter int CLK_FREQ     = 256,
  parameter int OUT_FREQ     = 1,
  parameter int NUM_CHANNELS = 10,
  localparam int PERIOD      = CLK_FREQ / OUT_FREQ,
  localparam int PHASE_W     = $clog2(PERIOD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [PHASE_W-1:0]      phases [NUM_CHANNELS],
  input  logic                    phases_valid,
  output logic                    pending,
  output logic                    running,
  output logic [NUM_CHANNELS-1:0] outs
`ifdef PHASE_DRIVER_SYNC_OUT_EN
  ,
  output logic                    sync_out
`endif
);

  localparam logic [PHASE_W-1:0]        LAST     = PHASE_W'(PERIOD - 1);
  localparam logic [PHASE_W-1:0]        HALF     = PHASE_W'(PERIOD / 2);
  localparam logic signed [PHASE_W:0]   PERIOD_S = (PHASE_W + 1)'(PERIOD);

  typedef enum logic [1:0] {S_OFF, S_ARMED, S_RUN, S_STOPPING} state_t;

  state_t                    state_q, state_d;
  logic [PHASE_W-1:0]        cnt_q, cnt_d;
  logic [PHASE_W-1:0]        shadow_q [NUM_CHANNELS];
  logic [PHASE_W-1:0]        shadow_d [NUM_CHANNELS];
  logic [PHASE_W-1:0]        active_q [NUM_CHANNELS];
  logic [PHASE_W-1:0]        active_d [NUM_CHANNELS];
  logic [PHASE_W-1:0]        phases_c [NUM_CHANNELS];
  logic signed [PHASE_W:0]   diff     [NUM_CHANNELS];
  logic                      pending_q, pending_d;
  logic                      loaded_q, loaded_d;
  logic                      running_q, running_d;
  logic                      sync_q, sync_d;
  logic [NUM_CHANNELS-1:0]   outs_q, outs_d;
  logic                      wrap;
  logic                      phase_on;

  // Out-of-range phases (only reachable when PERIOD is not a power of 2)
  // saturate to the last tick of the period.
  function automatic logic [PHASE_W-1:0] clamp_phase(input logic [PHASE_W-1:0] p);
    if (int'(p) >= PERIOD) return LAST;
    return p;
  endfunction

  assign wrap     = (cnt_q == LAST);
  assign phase_on = (state_q == S_RUN) || (state_q == S_STOPPING);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_OFF;
      cnt_q     <= '0;
      shadow_q  <= '{default: '0};
      active_q  <= '{default: '0};
      pending_q <= 1'b0;
      loaded_q  <= 1'b0;
      running_q <= 1'b0;
      sync_q    <= 1'b0;
      outs_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      loaded_q  <= loaded_d;
      running_q <= running_d;
      sync_q    <= sync_d;
      outs_q    <= outs_d;
    end
  end

  // Next-state logic. en takes priority over the boundary in STOPPING so a
  // re-request during the last tick continues without a gap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF:      if (en) state_d = S_ARMED;
      S_ARMED: begin
        if (!en)                                state_d = S_OFF;
        else if (wrap && (loaded_q || pending_q)) state_d = S_RUN;
      end
      S_RUN:      if (!en) state_d = S_STOPPING;
      S_STOPPING: begin
        if (en)        state_d = S_RUN;
        else if (wrap) state_d = S_OFF;
      end
      default:    state_d = S_OFF;
    endcase
  end

  // Counter and double-buffered phase banks; these run in every state.
  always_comb begin
    cnt_d     = wrap ? '0 : cnt_q + 1'b1;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    loaded_d  = loaded_q;
    for (int i = 0; i < NUM_CHANNELS; i++) phases_c[i] = clamp_phase(phases[i]);
    if (phases_valid) begin
      shadow_d = phases_c;
      if (wrap) begin
        // A strobe on the boundary tick bypasses the shadow wait.
        active_d  = phases_c;
        pending_d = 1'b0;
        loaded_d  = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end else if (wrap && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
      loaded_d  = 1'b1;
    end
  end

  // Output logic: a channel is high for the first half-period after its phase.
  always_comb begin
    running_d = phase_on;
    sync_d    = wrap && phase_on;
    outs_d    = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      diff[i] = $signed({1'b0, cnt_q}) - $signed({1'b0, active_q[i]});
      if (diff[i] < 0) diff[i] = diff[i] + PERIOD_S;
      outs_d[i] = phase_on && (diff[i][PHASE_W-1:0] < HALF);
    end
  end

  assign pending = pending_q;
  assign running = running_q;
  assign outs    = outs_q;

`ifdef PHASE_DRIVER_SYNC_OUT_EN
  assign sync_out = sync_q;
`else
  logic unused_sync;
  assign unused_sync = sync_q;
`endif

endmodule

// File: tb/tb_phase_driver.sv
// tb/tb_phase_driver.sv - self-checking bench for phase_driver

module tb_phase_driver;

  localparam int P   = 256;
  localparam int NCH = 10;
  localparam int P2  = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en  = 1'b0;
  logic           pv  = 1'b0;
  logic [7:0]     phases [NCH];
  logic           pending, running;
  logic [NCH-1:0] outs;

  logic           en2 = 1'b0;
  logic           pv2 = 1'b0;
  logic [3:0]     phases2 [2];
  logic           pending2, running2;
  logic [1:0]     outs2;

`ifdef PHASE_DRIVER_SYNC_OUT_EN
  logic           sync_out, sync_out2;
`endif

  int checks = 0;
  int errors = 0;
  int tb_cnt = 0;
  int tb_cnt2 = 0;
  int cp0, cp1, cp2;

  typedef struct {
    int             c;
    logic [NCH-1:0] outs;
    logic           run;
    int             act;
  } sb_item_t;

  typedef struct {
    int   p0, p1, p2;
    int   at;
    logic exp_pend;
  } vec_t;

  sb_item_t sb_q [$];
  vec_t     vt [4];

  phase_driver dut (
    .clk(clk), .rst(rst), .en(en), .phases(phases), .phases_valid(pv),
    .pending(pending), .running(running), .outs(outs)
`ifdef PHASE_DRIVER_SYNC_OUT_EN
    , .sync_out(sync_out)
`endif
  );

  phase_driver #(.CLK_FREQ(10), .OUT_FREQ(1), .NUM_CHANNELS(2)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .phases(phases2), .phases_valid(pv2),
    .pending(pending2), .running(running2), .outs(outs2)
`ifdef PHASE_DRIVER_SYNC_OUT_EN
    , .sync_out(sync_out2)
`endif
  );

  always #5 clk = ~clk;

  // Reference tick counters: value seen at a negedge equals the DUT's cnt.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      tb_cnt  <= 0;
      tb_cnt2 <= 0;
    end else begin
      tb_cnt  <= (tb_cnt + 1) % P;
      tb_cnt2 <= (tb_cnt2 + 1) % P2;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20)
        $display("FAIL %s at cnt %0d: got %0h, expected %0h", name, tb_cnt, act, exp);
    end
  endtask

  // Expected outputs at tick c: channel high when the tick one cycle earlier
  // lies in the first half-period after that channel's phase.
  function automatic logic [NCH-1:0] model_outs(input int c, input int p0, input int p1, input int p2);
    logic [NCH-1:0] r;
    int p, d;
    for (int i = 0; i < NCH; i++) begin
      p = (i == 0) ? p0 : (i == 1) ? p1 : p2;
      d = (((c - 1 - p) % P) + P) % P;
      r[i] = (d < P / 2);
    end
    return r;
  endfunction

  task automatic push(input int c0, input int n, input int p0, input int p1, input int p2,
                      input logic run, input int ac1 = -1, input int a1 = 0,
                      input int ac2 = -1, input int a2 = 0);
    sb_item_t it;
    for (int k = 0; k < n; k++) begin
      it.c    = (c0 + k) % P;
      it.run  = run;
      it.outs = run ? model_outs(it.c, p0, p1, p2) : '0;
      it.act  = (it.c == ac1) ? a1 : (it.c == ac2) ? a2 : 0;
      sb_q.push_back(it);
    end
  endtask

  task automatic drain();
    sb_item_t it;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      check("sb_outs", outs, it.outs);
      check("sb_running", running, it.run);
`ifdef PHASE_DRIVER_SYNC_OUT_EN
      check("sb_sync_out", sync_out, (it.c == 0) && it.run);
`endif
      if (it.c == 1) check("sb_pending_cleared", pending, 0);
      if (it.act == 1) en = 1'b0;
      if (it.act == 2) en = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic wait_cnt(input int v);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tb_cnt != v && n < 2 * P + 4);
    if (tb_cnt != v) check("wait_cnt_timeout", tb_cnt, v);
  endtask

  task automatic wait_cnt2(input int v);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tb_cnt2 != v && n < 2 * P2 + 4);
    if (tb_cnt2 != v) check("wait_cnt2_timeout", tb_cnt2, v);
  endtask

  task automatic apply(input int p0, input int p1, input int p2, input int at);
    wait_cnt(at);
    phases[0] = 8'(p0);
    phases[1] = 8'(p1);
    for (int i = 2; i < NCH; i++) phases[i] = 8'(p2);
    pv = 1'b1;
    @(negedge clk);
    pv = 1'b0;
  endtask

  initial begin
    int c;
    logic [1:0] e2;
    vt[0] = '{32, 96, 200, 100, 1'b1};
    vt[1] = '{255, 0, 17, 255, 1'b0};
    vt[2] = '{5, 250, 128, 1, 1'b1};
    vt[3] = '{100, 1, 254, 37, 1'b1};
    for (int i = 0; i < NCH; i++) phases[i] = '0;
    phases2[0] = '0;
    phases2[1] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_outs", outs, 0);
    check("rst_running", running, 0);
    check("rst_pending", pending, 0);
    check("rst_outs2", outs2, 0);
    check("rst_running2", running2, 0);
`ifdef PHASE_DRIVER_SYNC_OUT_EN
    check("rst_sync_out", sync_out, 0);
`endif
    rst = 1'b1;

    // First load and start
    en = 1'b1;
    apply(0, 64, 128, 20);
    check("t1_pending", pending, 1);
    check("t1_running", running, 0);
    wait_cnt(255);
    check("t1_pending_255", pending, 1);
    check("t1_outs_armed", outs, 0);
    check("t1_running_armed", running, 0);
    @(negedge clk);
    check("t1_pending_0", pending, 0);
    check("t1_running_0", running, 0);
    check("t1_outs_0", outs, 0);
    @(negedge clk);
    cp0 = 0; cp1 = 64; cp2 = 128;
    push(1, P, cp0, cp1, cp2, 1'b1);
    drain();

    // Table of phase updates while running, including a strobe on the wrap tick
    for (int v = 0; v < 4; v++) begin
      apply(vt[v].p0, vt[v].p1, vt[v].p2, vt[v].at);
      check("tbl_pending", pending, vt[v].exp_pend);
      c = tb_cnt;
      push(c, ((P - c) % P) + 1, cp0, cp1, cp2, 1'b1);
      push(1, P, vt[v].p0, vt[v].p1, vt[v].p2, 1'b1);
      drain();
      cp0 = vt[v].p0; cp1 = vt[v].p1; cp2 = vt[v].p2;
    end

    // Two updates in one period: the later one wins, nothing changes before wrap
    apply(32, cp1, cp2, 100);
    check("t2_pending_a", pending, 1);
    apply(40, cp1, cp2, 200);
    check("t2_pending_b", pending, 1);
    c = tb_cnt;
    push(c, P - c + 1, cp0, cp1, cp2, 1'b1);
    push(1, P, 40, cp1, cp2, 1'b1);
    drain();
    cp0 = 40;

    // Stop, restart, stop/resume without gap, stop on the wrap tick
    push(1, P, cp0, cp1, cp2, 1'b1, 10, 1);
    push(1, P, cp0, cp1, cp2, 1'b0, 30, 2);
    push(1, P, cp0, cp1, cp2, 1'b1, 10, 1, 50, 2);
    push(1, P, cp0, cp1, cp2, 1'b1, 255, 1);
    push(1, P, cp0, cp1, cp2, 1'b1);
    push(1, 20, cp0, cp1, cp2, 1'b0);
    drain();

    // Small period: no phases loaded keeps ARMED, then clamped phase
    en2 = 1'b1;
    repeat (35) begin
      @(negedge clk);
      check("t5_armed_outs2", outs2, 0);
      check("t5_armed_running2", running2, 0);
    end
    wait_cnt2(4);
    phases2[0] = 4'd12;
    phases2[1] = 4'd3;
    pv2 = 1'b1;
    @(negedge clk);
    pv2 = 1'b0;
    check("t5_pending2", pending2, 1);
    wait_cnt2(0);
    check("t5_pending2_applied", pending2, 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      e2[0] = ((((tb_cnt2 - 1 - 9) % P2) + P2) % P2) < P2 / 2;
      e2[1] = ((((tb_cnt2 - 1 - 3) % P2) + P2) % P2) < P2 / 2;
      check("t5_outs2", outs2, e2);
      check("t5_running2", running2, 1);
    end

    // Asynchronous reset while running with an update pending
    en = 1'b1;
    wait_cnt(255);
    wait_cnt(100);
    check("t6_running", running, 1);
    apply(7, 8, 9, 120);
    check("t6_pending", pending, 1);
    wait_cnt(130);
    check("t6_outs_pre", outs, model_outs(130, cp0, cp1, cp2));
    #2 rst = 1'b0;
    #1;
    check("t6_outs_async", outs, 0);
    check("t6_running_async", running, 0);
    check("t6_pending_async", pending, 0);
    check("t6_outs2_async", outs2, 0);
    check("t6_running2_async", running2, 0);
`ifdef PHASE_DRIVER_SYNC_OUT_EN
    check("t6_sync_async", sync_out, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (300) begin
      @(negedge clk);
      check("t6_post_outs", outs, 0);
      check("t6_post_running", running, 0);
    end
    en = 1'b0;
    en2 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
